// File: rtl/code_nco_gen.sv
// Code NCO driving a GPS L1 C/A Gold-code generator.
// Produces early/prompt/late replica chips half a chip apart and a 1 ms epoch on prompt chip 0.
module code_nco_gen #(
    parameter logic [31:0] CODE_FCW_NOM = 32'd439375954,
    parameter logic [31:0] FCW_MIN      = 32'd1,
    parameter logic [31:0] FCW_MAX      = 32'd2147483647
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        prn_load,
    input  logic [5:0]  prn,
    input  logic [31:0] correction,
    input  logic        correction_valid,
    output logic        code_e,
    output logic        code_p,
    output logic        code_l,
    output logic [9:0]  prompt_chip_idx,
    output logic        epoch
);

    localparam logic [10:1] G_ONES = '1;

    logic [31:0] r_phase;
    logic [31:0] r_fcw;
    logic [5:0]  r_prn;
    logic [10:1] r_g1;
    logic [10:1] r_g2;
    logic [9:0]  r_gen_idx;
    logic [2:0]  r_sr;
    logic        r_tag0;
    logic [9:0]  r_idx0;
    logic [9:0]  r_idx1;
    logic        r_epoch;

    logic [32:0]        w_sum;
    logic               w_wrap;
    logic               w_mid;
    logic               w_tick;
    logic signed [33:0] w_fcw_sum;
    logic [31:0]        w_fcw_clamped;
    logic               w_prn_ok;
    logic [7:0]         w_taps;
    logic [10:1]        w_m1;
    logic [10:1]        w_m2;
    logic [10:1]        w_g1_step;
    logic [10:1]        w_g2_step;
    logic [10:1]        w_g1_adv;
    logic [10:1]        w_g2_adv;
    logic               w_last_chip;
    logic [9:0]         w_idx_inc;
    logic               w_chip_cur;
    logic               w_chip_adv;
    logic               w_push_chip;
    logic [9:0]         w_push_idx;
    logic               w_push_tag;

    // G2 phase-select taps {s1, s2} for PRN 1..32.
    function automatic logic [7:0] g2_taps(input logic [5:0] p);
        case (p)
            6'd1:    g2_taps = {4'd2, 4'd6};
            6'd2:    g2_taps = {4'd3, 4'd7};
            6'd3:    g2_taps = {4'd4, 4'd8};
            6'd4:    g2_taps = {4'd5, 4'd9};
            6'd5:    g2_taps = {4'd1, 4'd9};
            6'd6:    g2_taps = {4'd2, 4'd10};
            6'd7:    g2_taps = {4'd1, 4'd8};
            6'd8:    g2_taps = {4'd2, 4'd9};
            6'd9:    g2_taps = {4'd3, 4'd10};
            6'd10:   g2_taps = {4'd2, 4'd3};
            6'd11:   g2_taps = {4'd3, 4'd4};
            6'd12:   g2_taps = {4'd5, 4'd6};
            6'd13:   g2_taps = {4'd6, 4'd7};
            6'd14:   g2_taps = {4'd7, 4'd8};
            6'd15:   g2_taps = {4'd8, 4'd9};
            6'd16:   g2_taps = {4'd9, 4'd10};
            6'd17:   g2_taps = {4'd1, 4'd4};
            6'd18:   g2_taps = {4'd2, 4'd5};
            6'd19:   g2_taps = {4'd3, 4'd6};
            6'd20:   g2_taps = {4'd4, 4'd7};
            6'd21:   g2_taps = {4'd5, 4'd8};
            6'd22:   g2_taps = {4'd6, 4'd9};
            6'd23:   g2_taps = {4'd1, 4'd3};
            6'd24:   g2_taps = {4'd4, 4'd6};
            6'd25:   g2_taps = {4'd5, 4'd7};
            6'd26:   g2_taps = {4'd6, 4'd8};
            6'd27:   g2_taps = {4'd7, 4'd9};
            6'd28:   g2_taps = {4'd8, 4'd10};
            6'd29:   g2_taps = {4'd1, 4'd6};
            6'd30:   g2_taps = {4'd2, 4'd7};
            6'd31:   g2_taps = {4'd3, 4'd8};
            6'd32:   g2_taps = {4'd4, 4'd9};
            default: g2_taps = {4'd2, 4'd6};
        endcase
    endfunction

    function automatic logic chip_of(input logic [10:1] g1, input logic [10:1] g2,
                                     input logic [10:1] m1, input logic [10:1] m2);
        return g1[10] ^ (^(g2 & m1)) ^ (^(g2 & m2));
    endfunction

    assign w_sum  = {1'b0, r_phase} + {1'b0, r_fcw};
    assign w_wrap = w_sum[32];
    assign w_mid  = ~r_phase[31] & w_sum[31];
    assign w_tick = enable & (w_wrap | w_mid);

    assign w_fcw_sum = $signed({2'b00, CODE_FCW_NOM}) + $signed({{2{correction[31]}}, correction});
    assign w_fcw_clamped = (w_fcw_sum < $signed({2'b00, FCW_MIN})) ? FCW_MIN :
                           (w_fcw_sum > $signed({2'b00, FCW_MAX})) ? FCW_MAX :
                           w_fcw_sum[31:0];

    assign w_prn_ok = prn_load & (prn != 6'd0) & (prn <= 6'd32);

    assign w_taps = g2_taps(r_prn);
    assign w_m1   = 10'd1 << (w_taps[7:4] - 4'd1);
    assign w_m2   = 10'd1 << (w_taps[3:0] - 4'd1);

    genvar gi;
    generate
        for (gi = 2; gi <= 10; gi++) begin : g_shift
            assign w_g1_step[gi] = r_g1[gi-1];
            assign w_g2_step[gi] = r_g2[gi-1];
        end
    endgenerate
    assign w_g1_step[1] = r_g1[3] ^ r_g1[10];
    assign w_g2_step[1] = r_g2[2] ^ r_g2[3] ^ r_g2[6] ^ r_g2[8] ^ r_g2[9] ^ r_g2[10];

    // Reload at the end of the 1023-chip period keeps G1/G2 aligned with gen_idx.
    assign w_last_chip = (r_gen_idx == 10'd1022);
    assign w_idx_inc   = w_last_chip ? 10'd0 : r_gen_idx + 10'd1;
    assign w_g1_adv    = w_last_chip ? G_ONES : w_g1_step;
    assign w_g2_adv    = w_last_chip ? G_ONES : w_g2_step;

    assign w_chip_cur  = chip_of(r_g1, r_g2, w_m1, w_m2);
    assign w_chip_adv  = chip_of(w_g1_adv, w_g2_adv, w_m1, w_m2);
    assign w_push_chip = w_wrap ? w_chip_adv : w_chip_cur;
    assign w_push_idx  = w_wrap ? w_idx_inc : r_gen_idx;
    assign w_push_tag  = w_wrap & (w_idx_inc == 10'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase   <= '0;
            r_fcw     <= CODE_FCW_NOM;
            r_prn     <= 6'd1;
            r_g1      <= G_ONES;
            r_g2      <= G_ONES;
            r_gen_idx <= '0;
            r_sr      <= '0;
            r_tag0    <= 1'b0;
            r_idx0    <= '0;
            r_idx1    <= '0;
            r_epoch   <= 1'b0;
        end else begin
            if (correction_valid) begin
                r_fcw <= w_fcw_clamped;
            end
            r_epoch <= ~w_prn_ok & w_tick & r_tag0;
            if (w_prn_ok) begin
                r_prn     <= prn;
                r_phase   <= '0;
                r_g1      <= G_ONES;
                r_g2      <= G_ONES;
                r_gen_idx <= '0;
                // Chip 0 is always 1 with both registers all ones, whatever the taps.
                r_sr      <= 3'b001;
                r_tag0    <= 1'b1;
                r_idx0    <= '0;
                r_idx1    <= '0;
            end else if (enable) begin
                r_phase <= w_sum[31:0];
                if (w_wrap) begin
                    r_g1      <= w_g1_adv;
                    r_g2      <= w_g2_adv;
                    r_gen_idx <= w_idx_inc;
                end
                if (w_tick) begin
                    r_sr   <= {r_sr[1:0], w_push_chip};
                    r_tag0 <= w_push_tag;
                    r_idx0 <= w_push_idx;
                    r_idx1 <= r_idx0;
                end
            end
        end
    end

    assign code_e          = r_sr[0];
    assign code_p          = r_sr[1];
    assign code_l          = r_sr[2];
    assign prompt_chip_idx = r_idx1;
    assign epoch           = r_epoch;

endmodule

// File: tb/tb_code_nco_gen.sv
// Directed bench for code_nco_gen: PRN sequences, chip timing, epoch spacing, clamp, hold and reset.
module tb_code_nco_gen;

    localparam logic [31:0] NOM = 32'd439375954;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b1;
    logic        prn_load = 1'b0;
    logic [5:0]  prn = 6'd0;
    logic [31:0] correction = 32'd0;
    logic        correction_valid = 1'b0;
    logic        code_e, code_p, code_l, epoch;
    logic [9:0]  prompt_chip_idx;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    code_nco_gen dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .prn_load         (prn_load),
        .prn              (prn),
        .correction       (correction),
        .correction_valid (correction_valid),
        .code_e           (code_e),
        .code_p           (code_p),
        .code_l           (code_l),
        .prompt_chip_idx  (prompt_chip_idx),
        .epoch            (epoch)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prn(input logic [5:0] p);
        prn      = p;
        prn_load = 1'b1;
        step();
        prn_load = 1'b0;
    endtask

    task automatic set_corr(input logic [31:0] c);
        correction       = c;
        correction_valid = 1'b1;
        step();
        correction_valid = 1'b0;
    endtask

    task automatic wait_epoch(input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!epoch && n < budget);
        if (!epoch) n = -1;
    endtask

    function automatic logic [13:0] outs();
        return {code_e, code_p, code_l, prompt_chip_idx, epoch};
    endfunction

    // Called right after a PRN load with nominal fcw; collects the first 10 prompt chips.
    task automatic capture_chips(input string tag, input logic [9:0] exp_chips, input bit inject);
        int n;
        int nchip;
        int last;
        logic [9:0] last_idx;
        logic [9:0] chips;
        int lens[9];
        int lens_exp[9];
        lens_exp = '{10, 10, 10, 9, 10, 10, 10, 10, 9};
        chips = '0;
        n = 0;
        while (!epoch && n < 100) begin
            step();
            n++;
        end
        check($sformatf("%s_first_epoch", tag), n, 5);
        chips[9] = code_p;
        nchip = 1;
        last = n;
        last_idx = prompt_chip_idx;
        while (nchip < 10 && n < 300) begin
            if (inject && (n == 20 || n == 30)) begin
                prn      = (n == 20) ? 6'd0 : 6'd40;
                prn_load = 1'b1;
            end
            step();
            prn_load = 1'b0;
            n++;
            if (prompt_chip_idx != last_idx) begin
                chips[9-nchip] = code_p;
                lens[nchip-1]  = n - last;
                last     = n;
                last_idx = prompt_chip_idx;
                nchip++;
            end
        end
        check($sformatf("%s_chips", tag), chips, exp_chips);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("%s_len%0d", tag, i), (nchip == 10) ? lens[i] : 0, lens_exp[i]);
        end
    endtask

    initial begin
        int n;
        int since;
        int mism;
        int last_chg;
        logic [9:0] last_idx;
        logic [13:0] snap;
        logic eh[64];

        repeat (3) step();
        check("reset_outputs", outs(), 14'h0);
        check("reset_fcw", dut.r_fcw, NOM);
        rst = 1'b1;
        step();

        load_prn(6'd1);
        capture_chips("prn1", 10'b1100100000, 1'b0);

        load_prn(6'd1);
        wait_epoch(100, n);
        check("prn1_gap0", n, 5);
        for (int k = 1; k <= 3; k++) begin
            wait_epoch(10100, n);
            check($sformatf("prn1_gap%0d", k), n, 10000);
        end

        load_prn(6'd2);
        capture_chips("prn2", 10'b1110010000, 1'b1);

        // fcw = 2^30 loaded together with the PRN restart.
        correction       = 32'd634365870;
        correction_valid = 1'b1;
        prn              = 6'd1;
        prn_load         = 1'b1;
        step();
        correction_valid = 1'b0;
        prn_load         = 1'b0;
        check("q_fcw", dut.r_fcw, 32'h4000_0000);
        wait_epoch(50, n);
        check("q_first_epoch", n, 2);
        since = 0;
        last_chg = 0;
        last_idx = prompt_chip_idx;
        for (int i = 0; i < 40; i++) begin
            eh[i] = code_e;
            if (i >= 4) begin
                check($sformatf("q_p_dly%0d", i), code_p, eh[i-2]);
                check($sformatf("q_l_dly%0d", i), code_l, eh[i-4]);
            end
            if (prompt_chip_idx != last_idx) begin
                check($sformatf("q_idx_len%0d", i), i - last_chg, 4);
                check($sformatf("q_idx_val%0d", i), prompt_chip_idx, last_idx + 10'd1);
                last_chg = i;
                last_idx = prompt_chip_idx;
            end
            step();
            since++;
        end
        wait_epoch(5000, n);
        check("q_epoch_gap", (n < 0) ? 0 : since + n, 4092);

        set_corr(32'h7FFF_FFFF);
        check("clamp_max", dut.r_fcw, 32'h7FFF_FFFF);
        set_corr(32'h8000_0000);
        check("clamp_min", dut.r_fcw, 32'd1);
        load_prn(6'd1);
        mism = 0;
        repeat (200) begin
            step();
            if (outs() !== 14'h2000) mism++;
        end
        check("clamp_min_idle", mism, 0);
        set_corr(32'd0);
        check("corr_zero_fcw", dut.r_fcw, NOM);

        load_prn(6'd1);
        wait_epoch(100, n);
        check("hold_first_epoch", n, 5);
        repeat (3000) step();
        snap   = outs();
        enable = 1'b0;
        mism   = 0;
        repeat (500) begin
            step();
            if (outs() !== snap) mism++;
        end
        check("hold_frozen", mism, 0);
        enable = 1'b1;
        wait_epoch(12000, n);
        check("hold_epoch_gap", (n < 0) ? 0 : 3500 + n, 10500);

        enable = 1'b0;
        load_prn(6'd2);
        check("dis_load", outs(), 14'h2000);
        repeat (20) step();
        check("dis_load_held", outs(), 14'h2000);
        enable = 1'b1;
        wait_epoch(100, n);
        check("dis_first_epoch", n, 5);

        repeat (37) step();
        #3;
        rst = 1'b0;
        #1;
        check("rst_async", outs(), 14'h0);
        step();
        step();
        rst = 1'b1;
        check("rst_release", outs(), 14'h0);
        load_prn(6'd1);
        wait_epoch(100, n);
        check("rst_first_epoch", n, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/code_nco_gen.md
Name: code_nco_gen

Overview:
- Code NCO plus GPS L1 C/A Gold-code generator, directly downstream of the DLL filter.
- Consumes the signed DLL correction word and advances a 32-bit code-phase accumulator at the 10 MHz sample clock.
- Produces early/prompt/late replica chips, spaced ±½ chip apart, for the correlators that feed the 10000-sample summation blocks.
- Emits a 1 ms epoch pulse aligned to prompt chip 0, used to frame integration.

Parameters:
- CODE_FCW_NOM, 439375954, nominal frequency control word: 1.023 MHz / 10 MHz × 2^32.
- FCW_MIN, 1, lower clamp on the effective FCW.
- FCW_MAX, 2147483647, upper clamp on the effective FCW (< ½ chip per clock).

Ports:
- clk  input  1  sample clock (10 MHz).
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  advance accumulator/generator when high; hold everything when low.
- prn_load  input  1  single-cycle strobe: latch prn and restart code.
- prn  input  6  satellite PRN, valid values 1..32.
- correction  input  32  signed DLL correction, added to CODE_FCW_NOM.
- correction_valid  input  1  single-cycle strobe: register correction.
- code_e  output  1  early chip (logic 0 = +1, logic 1 = −1).
- code_p  output  1  prompt chip.
- code_l  output  1  late chip.
- prompt_chip_idx  output  10  index 0..1022 of the current prompt chip.
- epoch  output  1  one-cycle pulse when prompt begins chip 0.

Behaviour:
- **Reset (rst low, async):**
  - phase=0, fcw=CODE_FCW_NOM, prn_reg=1, G1=G2=all ones, gen_idx=0.
  - Half-chip shift register sr[2:0] and tags cleared.
  - code_e/p/l=0, prompt_chip_idx=0, epoch=0.
  - Release is synchronous to clk. The generator is then in the post-load state for PRN 1, except sr[0] holds 0 until the first push.
- **Correction path:**
  - On correction_valid, fcw <= clamp(CODE_FCW_NOM + sign-extended correction, FCW_MIN, FCW_MAX), computed in 34-bit signed.
  - The new fcw is used from the next cycle. The last value is held between strobes.
- **Accumulator:** when enable is high, phase <= phase + fcw (mod 2^32) each cycle. Since fcw < 2^31, at most one tick occurs per cycle.
  - mid tick: bit 31 goes 0→1.
  - wrap tick: carry out of bit 31.
- **Generator:**
  - G1 taps 3,10; G2 taps 2,3,6,8,9,10; both shift one step per wrap tick.
  - chip = G1[10] XOR G2[s1] XOR G2[s2], with (s1,s2) per IS-GPS-200 Table 3-Ia for prn_reg.
  - gen_idx increments on each wrap tick; 1022→0 reloads G1/G2 to all ones.
- **Half-chip pipeline:** on every tick (mid or wrap), sr <= {sr[1:0], chip after the tick}.
  - Each entry carries a tag, set only for the first half of chip 0 (pushed at the wrap tick that enters gen_idx 0).
  - Each entry also carries its chip index.
  - code_e=sr[0], code_p=sr[1], code_l=sr[2].
  - prompt_chip_idx = index carried with sr[1].
- **Epoch:** epoch=1 for exactly the one cycle in which a tagged entry moves into sr[1]. Outputs are registered, so they reflect a tick one cycle after the tick cycle.
- **prn_load:**
  - prn in 1..32: prn_reg<=prn, phase<=0, G1=G2=all ones, gen_idx=0.
  - sr[0] <= chip 0 (tagged), sr[1] and sr[2] <= 0 untagged, epoch cleared.
  - prn outside 1..32: the strobe is ignored entirely.
  - Applies regardless of enable and has priority over accumulator advance that cycle.
- **Simultaneous events:** prn_load together with correction_valid — both take effect.
- **enable low:** all state and outputs hold; no epoch is generated.

Test Plan:
- Reset during active run (rst low mid-chip) → all outputs 0 immediately (asynchronous); after release + prn_load(prn=1), first epoch occurs after ½ chip.
- PRN 1 load, correction=0, enable=1 → first 10 prompt chips 1100100000 (octal 1440); chip lengths 9/10 cycles; first three epoch intervals 10000 cycles each.
- PRN 2 load → first 10 prompt chips 1110010000 (octal 1620). prn=0 and prn=40 strobes → sequence unchanged.
- correction = 2^30 − 439375954 (fcw=2^30) → code_p equals code_e delayed 2 cycles, code_l delayed 4 cycles; epoch every 4092 cycles; prompt_chip_idx increments every 4 cycles.
- correction=+2^31−1 → fcw clamps to 2147483647; correction=−2^31 → fcw clamps to 1 (one mid tick per 2^31 cycles; check fcw internally).
- enable low for 500 cycles mid-code → outputs frozen and the next epoch is delayed exactly 500 cycles. prn_load while enable low → restart values loaded and held.
